io_timer_bank: RTL
==================

IO_TIMER_BANK -- requirements
Module: io_timer_bank

Interface
REQ-001 SHALL have parameter ADDRBASE, default 16'h0030, meaning byte base address of the 40-byte register window.
REQ-002 SHALL have parameter NUM_TIMERS, default 4, meaning channel count, legal range 1..4.
REQ-003 SHALL have parameter COUNTER_WIDTH, default 16, meaning counter/reload/compare width, legal range 9..16.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state is on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port dread_addr  input  16  meaning byte address of the 16-bit read; the low byte is at the address, the high byte at address+1.
REQ-007 SHALL have port dread_data  output  16  meaning registered read data.
REQ-008 SHALL have port dwrite_addr  input  16  meaning byte address of the write.
REQ-009 SHALL have port dwrite_data  input  16  meaning write data, low byte to dwrite_addr.
REQ-010 SHALL have port dwrite_en  input  2  meaning byte enables: [0] writes dwrite_addr, [1] writes dwrite_addr+1.
REQ-011 SHALL have port interrupt  output  1  meaning OR of (pending AND enable).

Function
REQ-012 SHALL decode the following byte registers at ADDRBASE+offset:
- 0 = IRQ enable [2N-1:0]
- 1 = IRQ pending [2N-1:0], write-1-to-clear; bit 2n = channel n overflow, bit 2n+1 = channel n compare.
REQ-013 SHALL decode each channel n at ADDRBASE+8(n+1):
- +0 = config: [0] run, [1] oneshot, [2] cmp_en, [7:4] prescale exponent p
- +2/+3 = counter lo/hi
- +4/+5 = reload lo/hi
- +6/+7 = compare lo/hi
REQ-014 SHALL treat every byte as independently writable; bits above COUNTER_WIDTH and unused config/enable bits SHALL read 0 and ignore writes.
REQ-015 SHALL return dread_data one cycle after dread_addr is presented; unmapped bytes SHALL read 8'h00.
REQ-016 SHALL forward, per byte, dwrite_data to dread_data when that byte is written in the same cycle it is read.
REQ-017 SHALL keep one prescaler per channel; when run=1 it SHALL emit a tick every 2^p clocks (p=0: every clock); when run=0 it SHALL be held at 0.
REQ-018 SHALL increment the counter by 1 modulo 2^COUNTER_WIDTH on each tick.
REQ-019 SHALL, on a tick with the counter at all-ones, instead load reload into the counter and set the overflow pending bit.
REQ-020 SHALL, on that overflow tick with oneshot=1, also clear run.
REQ-021 SHALL set the compare pending bit on a tick whose new counter value equals compare, when cmp_en=1.
REQ-022 SHALL give a CPU byte write to the counter priority over a same-cycle tick for that byte; the other byte SHALL take its tick result.
REQ-023 SHALL give a hardware pending set priority over a same-cycle write-1-to-clear of the same bit.
REQ-024 SHALL restart the prescaler at 0 when config is written.
REQ-025 SHALL drive interrupt combinationally from the registered enable and pending, so it asserts the cycle after the pending set.

Reset
REQ-026 SHALL, on reset asserted, immediately clear all registers:
- enable, pending, config, counter, reload, prescalers = 0
- compare = all-ones
- dread_data = 16'h0000
- interrupt = 0
REQ-027 SHALL ignore writes and suppress ticks while reset is high, and SHALL resume from the reset state on the first edge after deassertion.

Structure
REQ-028 SHALL take register offsets, config bit positions and the NUM_TIMERS/COUNTER_WIDTH limit constants from a shared package io_timer_pkg.
REQ-029 SHALL implement one channel (prescaler, counter, reload, compare, event pulses) as sub-module io_timer_channel, instantiated NUM_TIMERS times by a generate loop.

Verification
REQ-030 SHALL cover the overflow/reload scenario: counter=16'hFFFE, reload=16'h1000, run=1, p=0 -> counter FFFF, then 1000; pending[0]=1; interrupt=1 one cycle later if enable[0]=1.
REQ-031 SHALL cover the oneshot/prescale scenario: oneshot=1, p=2, counter=16'hFFFF -> reload is loaded after 4 clocks, run reads 0, and the counter stays frozen thereafter.
REQ-032 SHALL cover the compare scenario: compare=16'h0005, cmp_en=1, counter=0, p=0 -> pending[1] is set on the 5th tick only, and a W1C of 8'h02 clears it.
REQ-033 SHALL cover the simultaneous-event scenario: a pending set and a W1C of the same bit in one cycle -> the bit remains 1.
REQ-034 SHALL cover the byte-lane scenario: dwrite_en=2'b10 at channel-1 counter lo -> only the hi byte changes; a same-cycle read of that address returns the forwarded byte.
REQ-035 SHALL cover the reset-mid-count scenario: reset asserted mid-count with a pending bit set -> all outputs are 0 without a clock edge, and compare reads 16'hFFFF after release.

Source files
------------

// File: rtl/io_timer_pkg.sv
// io_timer_pkg: shared constants, types and helpers for the io_timer bank.
//   - register window layout (byte offsets relative to ADDRBASE)
//   - config byte bit positions
//   - legal limits for NUM_TIMERS / COUNTER_WIDTH
//   - lane_write(): resolves which byte (if any) the two write lanes put
//     at a given window offset.
package io_timer_pkg;

  localparam int MIN_TIMERS        = 1;
  localparam int MAX_TIMERS        = 4;
  localparam int MIN_COUNTER_WIDTH = 9;
  localparam int MAX_COUNTER_WIDTH = 16;

  localparam int WINDOW_BYTES = 40;

  // Bank-level byte registers.
  localparam logic [15:0] OFF_IRQ_EN   = 16'd0;
  localparam logic [15:0] OFF_IRQ_PEND = 16'd1;

  // Channel n lives at CH_STRIDE*(n+1); these are offsets inside a channel.
  localparam logic [15:0] CH_STRIDE = 16'd8;
  localparam logic [15:0] CH_CFG    = 16'd0;
  localparam logic [15:0] CH_CNT    = 16'd2;
  localparam logic [15:0] CH_RLD    = 16'd4;
  localparam logic [15:0] CH_CMP    = 16'd6;

  // Config byte layout.
  localparam int CFG_RUN     = 0;
  localparam int CFG_ONESHOT = 1;
  localparam int CFG_CMP_EN  = 2;
  localparam int CFG_P_LSB   = 4;

  typedef struct packed {
    logic [3:0] p;
    logic       cmp_en;
    logic       oneshot;
    logic       run;
  } timer_cfg_t;

  // One byte-wide access result: hit flag plus the byte.
  typedef struct packed {
    logic       hit;
    logic [7:0] data;
  } byte_wr_t;

  // Lane 0 carries wdata[7:0] to off0, lane 1 carries wdata[15:8] to off1.
  // The two lanes always target different bytes, so at most one can hit.
  function automatic byte_wr_t lane_write(input logic [15:0] target,
                                          input logic [1:0]  en,
                                          input logic [15:0] off0,
                                          input logic [15:0] off1,
                                          input logic [15:0] wdata);
    byte_wr_t r;
    r = '0;
    if (en[0] && (off0 == target)) begin
      r.hit  = 1'b1;
      r.data = wdata[7:0];
    end else if (en[1] && (off1 == target)) begin
      r.hit  = 1'b1;
      r.data = wdata[15:8];
    end
    return r;
  endfunction

endpackage

// File: rtl/io_timer_channel.sv
// io_timer_channel: one timer channel (prescaler, counter, reload, compare).
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   cfg_we / cfg_wdata     - config byte write
//   *_we[1:0] / *_wdata    - per-byte writes for counter, reload, compare
//                            ([0] low byte, [1] high byte)
//   cfg_rdata              - config byte as it reads back (unused bits 0)
//   cnt, rld, cmp          - current register values
//   ovf_evt, cmp_evt       - single-cycle event pulses for the pending logic
module io_timer_channel
  import io_timer_pkg::*;
#(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [7:0]               cfg_wdata,
  input  logic [1:0]               cnt_we,
  input  logic [15:0]              cnt_wdata,
  input  logic [1:0]               rld_we,
  input  logic [15:0]              rld_wdata,
  input  logic [1:0]               cmp_we,
  input  logic [15:0]              cmp_wdata,
  output logic [7:0]               cfg_rdata,
  output logic [COUNTER_WIDTH-1:0] cnt,
  output logic [COUNTER_WIDTH-1:0] rld,
  output logic [COUNTER_WIDTH-1:0] cmp,
  output logic                     ovf_evt,
  output logic                     cmp_evt
);

  localparam int CW = COUNTER_WIDTH;

  timer_cfg_t    cfg_q, cfg_d;
  logic [15:0]   presc_q, presc_d, presc_last;
  logic [CW-1:0] cnt_q, cnt_d, rld_q, rld_d, cmp_q, cmp_d, tick_val;
  logic          tick, wrap;

  // Config bit 3 has no function.
  logic unused_cfg_bit;
  assign unused_cfg_bit = cfg_wdata[3];

  // Byte-wise overlay of CPU write data onto a register value.
  function automatic logic [CW-1:0] merge(input logic [CW-1:0] cur,
                                          input logic [1:0]    we,
                                          input logic [15:0]   wd);
    logic [CW-1:0] r;
    r = cur;
    if (we[0]) r[7:0]    = wd[7:0];
    if (we[1]) r[CW-1:8] = wd[CW-1:8];
    return r;
  endfunction

  always_comb begin
    presc_last = (16'd1 << cfg_q.p) - 16'd1;
    tick       = cfg_q.run && (presc_q == presc_last);
    wrap       = &cnt_q;
    tick_val   = wrap ? rld_q : cnt_q + CW'(1);
    ovf_evt    = tick && wrap;
    cmp_evt    = tick && cfg_q.cmp_en && (tick_val == cmp_q);

    // A CPU byte write overrides only the byte it targets.
    cnt_d = merge(tick ? tick_val : cnt_q, cnt_we, cnt_wdata);
    rld_d = merge(rld_q, rld_we, rld_wdata);
    cmp_d = merge(cmp_q, cmp_we, cmp_wdata);

    presc_d = (tick || !cfg_q.run) ? 16'd0 : presc_q + 16'd1;

    cfg_d = cfg_q;
    if (ovf_evt && cfg_q.oneshot) cfg_d.run = 1'b0;
    if (cfg_we) begin
      cfg_d.run     = cfg_wdata[CFG_RUN];
      cfg_d.oneshot = cfg_wdata[CFG_ONESHOT];
      cfg_d.cmp_en  = cfg_wdata[CFG_CMP_EN];
      cfg_d.p       = cfg_wdata[CFG_P_LSB +: 4];
      presc_d       = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q   <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      rld_q   <= '0;
      cmp_q   <= '1;
    end else begin
      cfg_q   <= cfg_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      cmp_q   <= cmp_d;
    end
  end

  assign cfg_rdata = {cfg_q.p, 1'b0, cfg_q.cmp_en, cfg_q.oneshot, cfg_q.run};
  assign cnt       = cnt_q;
  assign rld       = rld_q;
  assign cmp       = cmp_q;

endmodule

// File: rtl/io_timer_bank.sv
// io_timer_bank: bank of NUM_TIMERS memory-mapped timers with a shared
// interrupt enable / pending pair, in a 40-byte window at ADDRBASE.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   dread_addr        - byte address of 16-bit read (low byte at address)
//   dread_data        - registered read data, valid one cycle later
//   dwrite_addr/data  - write address and data (low byte to dwrite_addr)
//   dwrite_en[1:0]    - byte enables for dwrite_addr / dwrite_addr+1
//   interrupt         - OR of (pending AND enable)
module io_timer_bank
  import io_timer_pkg::*;
#(
  parameter logic [15:0] ADDRBASE      = 16'h0030,
  parameter int          NUM_TIMERS    = 4,
  parameter int          COUNTER_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dread_addr,
  output logic [15:0] dread_data,
  input  logic [15:0] dwrite_addr,
  input  logic [15:0] dwrite_data,
  input  logic [1:0]  dwrite_en,
  output logic        interrupt
);

  localparam int EW = 2 * NUM_TIMERS;
  localparam int CW = COUNTER_WIDTH;

  logic [15:0]           woff0, woff1, roff0, roff1;
  logic [EW-1:0]         en_q, en_d, pend_q, pend_d, hw_set, w1c;
  logic [NUM_TIMERS-1:0] ovf_evt, cmp_evt;
  logic [7:0]            ch_cfg [NUM_TIMERS];
  logic [CW-1:0]         ch_cnt [NUM_TIMERS];
  logic [CW-1:0]         ch_rld [NUM_TIMERS];
  logic [CW-1:0]         ch_cmp [NUM_TIMERS];
  logic [15:0]           rd_d, dread_data_q;
  byte_wr_t              en_wr, pend_wr, rd0, rd1, fw0, fw1;

  // Window-relative offsets; addresses below ADDRBASE wrap to large values
  // and therefore decode as unmapped.
  assign woff0 = dwrite_addr - ADDRBASE;
  assign woff1 = dwrite_addr + 16'd1 - ADDRBASE;
  assign roff0 = dread_addr - ADDRBASE;
  assign roff1 = dread_addr + 16'd1 - ADDRBASE;

  for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_ch
    localparam logic [15:0] CB = 16'(n + 1) * CH_STRIDE;
    byte_wr_t cfg_w, cnt_l, cnt_h, rld_l, rld_h, cmp_l, cmp_h;
    assign cfg_w = lane_write(CB + CH_CFG,        dwrite_en, woff0, woff1, dwrite_data);
    assign cnt_l = lane_write(CB + CH_CNT,        dwrite_en, woff0, woff1, dwrite_data);
    assign cnt_h = lane_write(CB + CH_CNT + 16'd1, dwrite_en, woff0, woff1, dwrite_data);
    assign rld_l = lane_write(CB + CH_RLD,        dwrite_en, woff0, woff1, dwrite_data);
    assign rld_h = lane_write(CB + CH_RLD + 16'd1, dwrite_en, woff0, woff1, dwrite_data);
    assign cmp_l = lane_write(CB + CH_CMP,        dwrite_en, woff0, woff1, dwrite_data);
    assign cmp_h = lane_write(CB + CH_CMP + 16'd1, dwrite_en, woff0, woff1, dwrite_data);

    io_timer_channel #(.COUNTER_WIDTH(CW)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .cfg_we    (cfg_w.hit),
      .cfg_wdata (cfg_w.data),
      .cnt_we    ({cnt_h.hit, cnt_l.hit}),
      .cnt_wdata ({cnt_h.data, cnt_l.data}),
      .rld_we    ({rld_h.hit, rld_l.hit}),
      .rld_wdata ({rld_h.data, rld_l.data}),
      .cmp_we    ({cmp_h.hit, cmp_l.hit}),
      .cmp_wdata ({cmp_h.data, cmp_l.data}),
      .cfg_rdata (ch_cfg[n]),
      .cnt       (ch_cnt[n]),
      .rld       (ch_rld[n]),
      .cmp       (ch_cmp[n]),
      .ovf_evt   (ovf_evt[n]),
      .cmp_evt   (cmp_evt[n])
    );
  end

  // Byte read decode; hit marks a mapped byte (eligible for forwarding).
  function automatic byte_wr_t reg_read(input logic [15:0] off);
    byte_wr_t    r;
    logic [15:0] ch_idx;
    r      = '0;
    ch_idx = (off >> 3) - 16'd1;
    if (off == OFF_IRQ_EN) begin
      r.hit  = 1'b1;
      r.data = 8'(en_q);
    end else if (off == OFF_IRQ_PEND) begin
      r.hit  = 1'b1;
      r.data = 8'(pend_q);
    end else if ((off >= CH_STRIDE) && (off < 16'(WINDOW_BYTES))) begin
      for (int n = 0; n < NUM_TIMERS; n++) begin
        if (ch_idx == 16'(n)) begin
          case (off[2:0])
            3'(CH_CFG):       begin r.hit = 1'b1; r.data = ch_cfg[n];              end
            3'(CH_CNT):       begin r.hit = 1'b1; r.data = ch_cnt[n][7:0];         end
            3'(CH_CNT + 16'd1): begin r.hit = 1'b1; r.data = 8'(ch_cnt[n][CW-1:8]); end
            3'(CH_RLD):       begin r.hit = 1'b1; r.data = ch_rld[n][7:0];         end
            3'(CH_RLD + 16'd1): begin r.hit = 1'b1; r.data = 8'(ch_rld[n][CW-1:8]); end
            3'(CH_CMP):       begin r.hit = 1'b1; r.data = ch_cmp[n][7:0];         end
            3'(CH_CMP + 16'd1): begin r.hit = 1'b1; r.data = 8'(ch_cmp[n][CW-1:8]); end
            default: ;
          endcase
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    rd0  = reg_read(roff0);
    rd1  = reg_read(roff1);
    fw0  = lane_write(roff0, dwrite_en, woff0, woff1, dwrite_data);
    fw1  = lane_write(roff1, dwrite_en, woff0, woff1, dwrite_data);
    // A byte written in the same cycle reads back as the incoming data.
    rd_d = {(rd1.hit && fw1.hit) ? fw1.data : rd1.data,
            (rd0.hit && fw0.hit) ? fw0.data : rd0.data};

    en_wr   = lane_write(OFF_IRQ_EN,   dwrite_en, woff0, woff1, dwrite_data);
    pend_wr = lane_write(OFF_IRQ_PEND, dwrite_en, woff0, woff1, dwrite_data);

    hw_set = '0;
    for (int n = 0; n < NUM_TIMERS; n++) begin
      hw_set[2*n]   = ovf_evt[n];
      hw_set[2*n+1] = cmp_evt[n];
    end

    w1c    = pend_wr.hit ? pend_wr.data[EW-1:0] : '0;
    en_d   = en_wr.hit ? en_wr.data[EW-1:0] : en_q;
    // Hardware set is OR-ed after the clear so it wins a same-cycle W1C.
    pend_d = (pend_q & ~w1c) | hw_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q         <= '0;
      pend_q       <= '0;
      dread_data_q <= '0;
    end else begin
      en_q         <= en_d;
      pend_q       <= pend_d;
      dread_data_q <= rd_d;
    end
  end

  assign dread_data = dread_data_q;
  assign interrupt  = |(en_q & pend_q);

endmodule
